// File: rtl/rca_grid_sched_pkg.sv
// Shared constants, config-entry layout and FSM state type for the RCA grid scheduler.
package rca_grid_sched_pkg;

  localparam int NUM_RCAS        = 4;
  localparam int GRID_NUM_ROWS   = 2;
  localparam int GRID_NUM_COLS   = 2;
  localparam int NUM_GRID_MUXES  = GRID_NUM_ROWS * GRID_NUM_COLS;
  localparam int GRID_SEL_W      = 3;
  localparam int IO_SEL_W        = 2;
  localparam int CFG_DATA_W      = 8;
  localparam int MAX_OUTSTANDING = 4;
  localparam int XLEN            = 32;

  localparam int NUM_CFG_ENTRIES = NUM_GRID_MUXES + GRID_NUM_ROWS + 1;
  localparam int RCA_W     = $clog2(NUM_RCAS);
  localparam int IDX_W     = $clog2(NUM_CFG_ENTRIES);
  localparam int ROW_W     = (GRID_NUM_ROWS > 1) ? $clog2(GRID_NUM_ROWS) : 1;
  localparam int MUX_IDX_W = (NUM_GRID_MUXES > 1) ? $clog2(NUM_GRID_MUXES) : 1;
  localparam int OUTST_W   = $clog2(MAX_OUTSTANDING + 1);

  localparam int IO_BASE          = NUM_GRID_MUXES;
  localparam int META_IDX         = NUM_GRID_MUXES + GRID_NUM_ROWS;
  localparam int IO_MODE_BIT      = CFG_DATA_W - 1;
  localparam int META_MASK_LSB    = 0;
  localparam int META_OUT_ROW_LSB = GRID_NUM_ROWS;

  localparam logic [IDX_W-1:0]   IO_BASE_V   = IDX_W'(IO_BASE);
  localparam logic [IDX_W-1:0]   META_IDX_V  = IDX_W'(META_IDX);
  localparam logic [OUTST_W-1:0] MAX_OUTST_V = OUTST_W'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_IO_RST = 3'd2,
    ST_READY  = 3'd3,
    ST_DRAIN  = 3'd4
  } sched_state_t;

  typedef logic [CFG_DATA_W-1:0] cfg_entry_t;

  // Entries past the meta entry do not exist; writes to them are dropped.
  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return (idx <= META_IDX_V);
  endfunction

endpackage

// File: rtl/rca_grid_sched_if.sv
// Bus bundle between the scheduler, its requester/config port and the PR grid.
interface rca_grid_sched_if;
  import rca_grid_sched_pkg::*;

  logic                                       cfg_wr_en;
  logic [RCA_W-1:0]                           cfg_wr_rca;
  logic [IDX_W-1:0]                           cfg_wr_idx;
  logic [CFG_DATA_W-1:0]                      cfg_wr_data;
  logic                                       req_valid;
  logic [RCA_W-1:0]                           req_rca;
  logic                                       req_ready;
  logic [GRID_NUM_ROWS-1:0]                   rs_data_valid;
  logic [GRID_NUM_ROWS-1:0][XLEN-1:0]         io_unit_data_out;
  logic [GRID_NUM_ROWS-1:0]                   io_unit_data_valid_out;
  logic [GRID_NUM_ROWS-1:0]                   io_fifo_pop;
  logic                                       result_valid;
  logic [XLEN-1:0]                            result_data;
  logic                                       result_ready;
  logic [NUM_GRID_MUXES-1:0][GRID_SEL_W-1:0]  grid_mux_sel;
  logic [GRID_NUM_ROWS-1:0][IO_SEL_W-1:0]     curr_io_mux_sel;
  logic [GRID_NUM_ROWS-1:0]                   io_unit_output_mode;
  logic                                       io_units_rst;
  logic                                       busy;

  modport master (
    output cfg_wr_en, cfg_wr_rca, cfg_wr_idx, cfg_wr_data,
    output req_valid, req_rca, io_unit_data_out, io_unit_data_valid_out, result_ready,
    input  req_ready, rs_data_valid, io_fifo_pop, result_valid, result_data,
    input  grid_mux_sel, curr_io_mux_sel, io_unit_output_mode, io_units_rst, busy
  );

  modport slave (
    input  cfg_wr_en, cfg_wr_rca, cfg_wr_idx, cfg_wr_data,
    input  req_valid, req_rca, io_unit_data_out, io_unit_data_valid_out, result_ready,
    output req_ready, rs_data_valid, io_fifo_pop, result_valid, result_data,
    output grid_mux_sel, curr_io_mux_sel, io_unit_output_mode, io_units_rst, busy
  );

endinterface

// File: rtl/rca_grid_sched_cfg_store.sv
// Per-RCA configuration store: one synchronous write port, one combinational read port.
module rca_grid_sched_cfg_store
  import rca_grid_sched_pkg::*;
(
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [RCA_W-1:0] wr_rca_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  cfg_entry_t       wr_data_i,
  input  logic [RCA_W-1:0] rd_rca_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output cfg_entry_t       rd_data_o
);

  // Contents survive reset so a reset controller can reload without rewriting.
  cfg_entry_t mem_q [NUM_RCAS][NUM_CFG_ENTRIES];

  always_ff @(posedge clk_i) begin
    if (wr_en_i && idx_in_range(wr_idx_i)) begin
      mem_q[wr_rca_i][wr_idx_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_data_o = '0;
    if (idx_in_range(rd_idx_i)) begin
      rd_data_o = mem_q[rd_rca_i][rd_idx_i];
    end else begin
      rd_data_o = '0;
    end
  end

endmodule

// File: rtl/rca_grid_sched.sv
// Sequencing controller for the RCA PR grid: loads a stored configuration, gates
// operand issue, retires results from the output row and drains before switching RCAs.
module rca_grid_sched
  import rca_grid_sched_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  rca_grid_sched_if.slave   bus
);

  sched_state_t                              state_q, state_d;
  logic [RCA_W-1:0]                          target_q, target_d;
  logic [RCA_W-1:0]                          loaded_rca_q, loaded_rca_d;
  logic                                      loaded_valid_q, loaded_valid_d;
  logic                                      dirty_q, dirty_d;
  logic [IDX_W-1:0]                          cnt_q, cnt_d;
  logic [OUTST_W-1:0]                        outst_q, outst_d;
  logic [NUM_GRID_MUXES-1:0][GRID_SEL_W-1:0] grid_sel_q, grid_sel_d;
  logic [GRID_NUM_ROWS-1:0][IO_SEL_W-1:0]    io_sel_q, io_sel_d;
  logic [GRID_NUM_ROWS-1:0]                  io_mode_q, io_mode_d;
  logic [GRID_NUM_ROWS-1:0]                  in_mask_q, in_mask_d;
  logic [ROW_W-1:0]                          out_row_q, out_row_d;

  cfg_entry_t               rd_data_s;
  logic [IDX_W-1:0]         io_off_s;
  logic                     cfg_wr_ok_s, cfg_hit_target_s, cfg_hit_loaded_s;
  logic                     req_hit_s, req_ready_s, fire_s;
  logic                     active_s, outst_zero_s, outst_room_s;
  logic                     result_valid_s, pop_s;
  logic [GRID_NUM_ROWS-1:0] pop_vec_s;
  logic                     unused_cfg_bits_s;

  rca_grid_sched_cfg_store u_cfg_store (
    .clk_i     (clk_i),
    .wr_en_i   (bus.cfg_wr_en),
    .wr_rca_i  (bus.cfg_wr_rca),
    .wr_idx_i  (bus.cfg_wr_idx),
    .wr_data_i (bus.cfg_wr_data),
    .rd_rca_i  (target_q),
    .rd_idx_i  (cnt_q),
    .rd_data_o (rd_data_s)
  );

  assign cfg_wr_ok_s      = bus.cfg_wr_en & idx_in_range(bus.cfg_wr_idx);
  assign cfg_hit_target_s = cfg_wr_ok_s & (bus.cfg_wr_rca == target_q);
  assign cfg_hit_loaded_s = cfg_wr_ok_s & (bus.cfg_wr_rca == loaded_rca_q);

  assign req_hit_s      = loaded_valid_q & (bus.req_rca == loaded_rca_q);
  assign outst_zero_s   = (outst_q == '0);
  assign outst_room_s   = (outst_q < MAX_OUTST_V);
  assign req_ready_s    = (state_q == ST_READY) & req_hit_s & outst_room_s;
  assign fire_s         = bus.req_valid & req_ready_s;
  assign active_s       = (state_q == ST_READY) | (state_q == ST_DRAIN);
  assign result_valid_s = bus.io_unit_data_valid_out[out_row_q] & ~outst_zero_s & active_s;
  assign pop_s          = result_valid_s & bus.result_ready;

  assign io_off_s          = cnt_q - IO_BASE_V;
  assign unused_cfg_bits_s = ^{rd_data_s, io_off_s};

  // Next state, load target and validity tracking.
  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    cnt_d          = cnt_q;
    dirty_d        = dirty_q;
    loaded_rca_d   = loaded_rca_q;
    loaded_valid_d = loaded_valid_q;

    if (cfg_hit_loaded_s) begin
      loaded_valid_d = 1'b0;
    end else begin
      loaded_valid_d = loaded_valid_q;
    end

    // A write racing the load means the grid may hold a stale entry.
    if (((state_q == ST_LOAD) || (state_q == ST_IO_RST)) && cfg_hit_target_s) begin
      dirty_d = 1'b1;
    end else begin
      dirty_d = dirty_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_d        = ST_LOAD;
          target_d       = bus.req_rca;
          cnt_d          = '0;
          dirty_d        = 1'b0;
          loaded_valid_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (cnt_q == META_IDX_V) begin
          state_d = ST_IO_RST;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      ST_IO_RST: begin
        state_d        = ST_READY;
        loaded_rca_d   = target_q;
        loaded_valid_d = ~(dirty_q | cfg_hit_target_s);
      end
      ST_READY: begin
        if (bus.req_valid && !req_hit_s) begin
          if (outst_zero_s) begin
            state_d        = ST_LOAD;
            target_d       = bus.req_rca;
            cnt_d          = '0;
            dirty_d        = 1'b0;
            loaded_valid_d = 1'b0;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          state_d = ST_READY;
        end
      end
      ST_DRAIN: begin
        if (outst_zero_s) begin
          state_d        = ST_LOAD;
          target_d       = bus.req_rca;
          cnt_d          = '0;
          dirty_d        = 1'b0;
          loaded_valid_d = 1'b0;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d        = ST_IDLE;
        loaded_valid_d = 1'b0;
      end
    endcase
  end

  // Config entry decode: each LOAD cycle lands one entry in its grid register.
  always_comb begin
    grid_sel_d = grid_sel_q;
    io_sel_d   = io_sel_q;
    io_mode_d  = io_mode_q;
    in_mask_d  = in_mask_q;
    out_row_d  = out_row_q;
    if (state_q == ST_LOAD) begin
      if (cnt_q < IO_BASE_V) begin
        grid_sel_d[cnt_q[MUX_IDX_W-1:0]] = rd_data_s[GRID_SEL_W-1:0];
      end else if (cnt_q < META_IDX_V) begin
        io_sel_d[io_off_s[ROW_W-1:0]]  = rd_data_s[IO_SEL_W-1:0];
        io_mode_d[io_off_s[ROW_W-1:0]] = rd_data_s[IO_MODE_BIT];
      end else begin
        in_mask_d = rd_data_s[META_MASK_LSB +: GRID_NUM_ROWS];
        out_row_d = rd_data_s[META_OUT_ROW_LSB +: ROW_W];
      end
    end else begin
      grid_sel_d = grid_sel_q;
    end
  end

  // Outstanding-operation count; simultaneous issue and retire cancel out.
  always_comb begin
    outst_d = outst_q;
    case ({fire_s, pop_s})
      2'b10:   outst_d = outst_q + OUTST_W'(1);
      2'b01:   outst_d = outst_q - OUTST_W'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_comb begin
    pop_vec_s = '0;
    if (pop_s) begin
      pop_vec_s[out_row_q] = 1'b1;
    end else begin
      pop_vec_s = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      target_q       <= '0;
      loaded_rca_q   <= '0;
      loaded_valid_q <= 1'b0;
      dirty_q        <= 1'b0;
      cnt_q          <= '0;
      outst_q        <= '0;
      grid_sel_q     <= '0;
      io_sel_q       <= '0;
      io_mode_q      <= '0;
      in_mask_q      <= '0;
      out_row_q      <= '0;
    end else begin
      state_q        <= state_d;
      target_q       <= target_d;
      loaded_rca_q   <= loaded_rca_d;
      loaded_valid_q <= loaded_valid_d;
      dirty_q        <= dirty_d;
      cnt_q          <= cnt_d;
      outst_q        <= outst_d;
      grid_sel_q     <= grid_sel_d;
      io_sel_q       <= io_sel_d;
      io_mode_q      <= io_mode_d;
      in_mask_q      <= in_mask_d;
      out_row_q      <= out_row_d;
    end
  end

  assign bus.req_ready           = req_ready_s;
  assign bus.rs_data_valid       = fire_s ? in_mask_q : '0;
  assign bus.result_valid        = result_valid_s;
  assign bus.result_data         = result_valid_s ? bus.io_unit_data_out[out_row_q] : '0;
  assign bus.io_fifo_pop         = pop_vec_s;
  assign bus.grid_mux_sel        = grid_sel_q;
  assign bus.curr_io_mux_sel     = io_sel_q;
  assign bus.io_unit_output_mode = io_mode_q;
  assign bus.io_units_rst        = (state_q == ST_IO_RST);
  assign bus.busy                = (state_q != ST_IDLE) && (state_q != ST_READY);

endmodule

// File: tb/tb_rca_grid_sched.sv
// Directed bench for rca_grid_sched: load, issue limit, retire, drain/switch, reload, reset.
module tb_rca_grid_sched;
  import rca_grid_sched_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  localparam logic [3:0][2:0] GRID1  = {3'd4, 3'd3, 3'd2, 3'd1};
  localparam logic [3:0][2:0] GRID1B = {3'd4, 3'd3, 3'd2, 3'd7};
  localparam logic [3:0][2:0] GRID2  = {3'd0, 3'd7, 3'd6, 3'd5};
  localparam logic [1:0][1:0] IOS1   = {2'd2, 2'd1};
  localparam logic [1:0][1:0] IOS2   = {2'd0, 2'd3};

  rca_grid_sched_if bus();

  rca_grid_sched dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] rca, input logic [2:0] idx, input logic [7:0] data);
    bus.cfg_wr_en   = 1'b1;
    bus.cfg_wr_rca  = rca;
    bus.cfg_wr_idx  = idx;
    bus.cfg_wr_data = data;
    step();
    bus.cfg_wr_en = 1'b0;
  endtask

  // Issue a request that misses, then follow LOAD/IO_RST until READY.
  task automatic run_load(input logic [1:0] rca, input bit hold_req, output int load_cyc,
                          output int rst_cyc, output bit rdy, output logic [1:0] rs, output bit timeout);
    bit done;
    bus.req_valid = 1'b1;
    bus.req_rca   = rca;
    step();
    if (!hold_req) bus.req_valid = 1'b0;
    load_cyc = 0; rst_cyc = 0; rdy = 1'b0; rs = 2'b00; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.io_units_rst) rst_cyc++;
      else if (bus.busy) load_cyc++;
      else begin
        done = 1'b1;
        rdy  = bus.req_ready;
        rs   = bus.rs_data_valid;
      end
      step();
    end
    bus.req_valid = 1'b0;
    timeout = ~done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.grid_mux_sel, bus.curr_io_mux_sel, bus.io_unit_output_mode} !== 18'd0) begin
      bad++; $display("FAIL reset_regs got=%h exp=0", {bus.grid_mux_sel, bus.curr_io_mux_sel, bus.io_unit_output_mode});
    end
    total++;
    if ({bus.io_units_rst, bus.busy, bus.req_ready, bus.rs_data_valid, bus.result_valid, bus.io_fifo_pop} !== 8'd0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0", {bus.io_units_rst, bus.busy, bus.req_ready, bus.rs_data_valid, bus.result_valid, bus.io_fifo_pop});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    // RCA1: grid 1,2,3,4; IO sel 1 (mode 0), sel 2 (mode 1); mask 01, out_row 1.
    cfg_write(2'd1, 3'd0, 8'h01); cfg_write(2'd1, 3'd1, 8'h02);
    cfg_write(2'd1, 3'd2, 8'h03); cfg_write(2'd1, 3'd3, 8'h04);
    cfg_write(2'd1, 3'd4, 8'h01); cfg_write(2'd1, 3'd5, 8'h82);
    cfg_write(2'd1, 3'd6, 8'h05);
    // RCA2: grid 5,6,7,0; IO sel 3 (mode 1), sel 0 (mode 0); mask 10, out_row 0.
    cfg_write(2'd2, 3'd0, 8'h05); cfg_write(2'd2, 3'd1, 8'h06);
    cfg_write(2'd2, 3'd2, 8'h07); cfg_write(2'd2, 3'd3, 8'h00);
    cfg_write(2'd2, 3'd4, 8'h83); cfg_write(2'd2, 3'd5, 8'h00);
    cfg_write(2'd2, 3'd6, 8'h02);
  endtask

  task automatic test_load();
    int lc, rc; bit rdy, to; logic [1:0] rs;
    run_load(2'd1, 1'b0, lc, rc, rdy, rs, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL load_timeout got=%0b exp=0", to); end
    total++; if (lc !== 7) begin bad++; $display("FAIL load_cycles got=%0d exp=7", lc); end
    total++; if (rc !== 1) begin bad++; $display("FAIL io_rst_cycles got=%0d exp=1", rc); end
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL load_ready got=%0b exp=1", rdy); end
    total++; if (bus.grid_mux_sel !== GRID1) begin bad++; $display("FAIL load_grid got=%h exp=%h", bus.grid_mux_sel, GRID1); end
    total++; if (bus.curr_io_mux_sel !== IOS1) begin bad++; $display("FAIL load_iosel got=%h exp=%h", bus.curr_io_mux_sel, IOS1); end
    total++; if (bus.io_unit_output_mode !== 2'b10) begin bad++; $display("FAIL load_mode got=%b exp=10", bus.io_unit_output_mode); end
  endtask

  task automatic test_issue_limit();
    int fires = 0;
    bus.req_valid = 1'b1; bus.req_rca = 2'd1; bus.result_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (bus.req_ready) begin
        fires++;
        if (bus.rs_data_valid !== 2'b01) begin bad++; $display("FAIL issue_rs got=%b exp=01", bus.rs_data_valid); end
      end else begin
        if (bus.rs_data_valid !== 2'b00) begin bad++; $display("FAIL issue_rs_idle got=%b exp=00", bus.rs_data_valid); end
      end
      step();
    end
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL issue_full_ready got=%b exp=0", bus.req_ready); end
    total++; if (fires !== 4) begin bad++; $display("FAIL issue_fires got=%0d exp=4", fires); end
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic test_retire();
    bus.io_unit_data_out[1] = 32'hDEADBEEF;
    bus.io_unit_data_out[0] = 32'h12345678;
    bus.io_unit_data_valid_out = 2'b10;
    bus.result_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.result_valid !== 1'b1) begin bad++; $display("FAIL ret_valid got=%b exp=1", bus.result_valid); end
    total++; if (bus.result_data !== 32'hDEADBEEF) begin bad++; $display("FAIL ret_data got=%h exp=deadbeef", bus.result_data); end
    total++; if (bus.io_fifo_pop !== 2'b10) begin bad++; $display("FAIL ret_pop got=%b exp=10", bus.io_fifo_pop); end
    step();
    bus.req_valid = 1'b1; bus.req_rca = 2'd1;
    @(negedge clk);
    total++; if ({bus.req_ready, bus.io_fifo_pop, bus.rs_data_valid} !== 5'b1_10_01) begin
      bad++; $display("FAIL ret_fire_pop got=%b exp=11001", {bus.req_ready, bus.io_fifo_pop, bus.rs_data_valid});
    end
    step();
    bus.result_ready = 1'b0;
    @(negedge clk);
    total++; if ({bus.req_ready, bus.result_valid, bus.io_fifo_pop} !== 4'b1_1_00) begin
      bad++; $display("FAIL ret_count3 got=%b exp=1100", {bus.req_ready, bus.result_valid, bus.io_fifo_pop});
    end
    step();
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL ret_count4 got=%b exp=0", bus.req_ready); end
    step();
    bus.req_valid = 1'b0; bus.result_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (bus.io_fifo_pop !== 2'b10) begin bad++; $display("FAIL ret_drain_pop%0d got=%b exp=10", i, bus.io_fifo_pop); end
      step();
    end
    bus.result_ready = 1'b0; bus.io_unit_data_valid_out = 2'b00;
  endtask

  task automatic test_drain_switch();
    int pops = 0, rc = 0; bit early = 1'b0, done = 1'b0, rdy = 1'b0; logic [1:0] rs = 2'b00;
    bus.req_valid = 1'b1; bus.req_rca = 2'd2;
    @(negedge clk);
    total++; if ({bus.req_ready, bus.busy} !== 2'b00) begin bad++; $display("FAIL drn_miss got=%b exp=00", {bus.req_ready, bus.busy}); end
    step();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if ({bus.busy, bus.io_units_rst, bus.result_valid} !== 3'b100) begin
        bad++; $display("FAIL drn_hold got=%b exp=100", {bus.busy, bus.io_units_rst, bus.result_valid});
      end
      step();
    end
    bus.io_unit_data_out[1] = 32'h11111111; bus.io_unit_data_valid_out = 2'b10; bus.result_ready = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.io_fifo_pop == 2'b10) pops++;
      if (bus.io_units_rst) begin rc++; if (pops < 2) early = 1'b1; end
      if (!bus.busy && !bus.io_units_rst) begin done = 1'b1; rdy = bus.req_ready; rs = bus.rs_data_valid; end
      step();
      if (pops >= 2) begin bus.io_unit_data_valid_out = 2'b00; bus.result_ready = 1'b0; end
    end
    bus.req_valid = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL drn_timeout got=%0b exp=1", done); end
    total++; if (pops !== 2) begin bad++; $display("FAIL drn_pops got=%0d exp=2", pops); end
    total++; if (rc !== 1 || early !== 1'b0) begin bad++; $display("FAIL drn_iorst got=%0d early=%0b exp=1/0", rc, early); end
    total++; if (bus.grid_mux_sel !== GRID2) begin bad++; $display("FAIL drn_grid got=%h exp=%h", bus.grid_mux_sel, GRID2); end
    total++; if ({rdy, rs} !== 3'b1_10) begin bad++; $display("FAIL drn_fire got=%b exp=110", {rdy, rs}); end
    // RCA2 retires from row 0.
    bus.io_unit_data_out[0] = 32'hCAFEF00D; bus.io_unit_data_valid_out = 2'b01; bus.result_ready = 1'b1;
    @(negedge clk);
    total++; if ({bus.result_valid, bus.io_fifo_pop} !== 3'b1_01 || bus.result_data !== 32'hCAFEF00D) begin
      bad++; $display("FAIL row0_ret got=%b data=%h exp=101 cafef00d", {bus.result_valid, bus.io_fifo_pop}, bus.result_data);
    end
    step();
    @(negedge clk);
    total++; if ({bus.result_valid, bus.io_fifo_pop} !== 3'b0_00) begin
      bad++; $display("FAIL no_underflow got=%b exp=000", {bus.result_valid, bus.io_fifo_pop});
    end
    step();
    bus.io_unit_data_valid_out = 2'b00; bus.result_ready = 1'b0;
  endtask

  task automatic test_cfg_invalidate();
    int lc, rc; bit rdy, to; logic [1:0] rs;
    run_load(2'd1, 1'b0, lc, rc, rdy, rs, to);
    total++; if ({to, rdy} !== 2'b01 || bus.grid_mux_sel !== GRID1) begin
      bad++; $display("FAIL inv_preload to=%0b rdy=%0b grid=%h exp=0/1/%h", to, rdy, bus.grid_mux_sel, GRID1);
    end
    bus.cfg_wr_en = 1'b1; bus.cfg_wr_rca = 2'd1; bus.cfg_wr_idx = 3'd0; bus.cfg_wr_data = 8'h07;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL inv_same_cycle got=%b exp=1", bus.req_ready); end
    step();
    bus.cfg_wr_en = 1'b0;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL inv_ready_drop got=%b exp=0", bus.req_ready); end
    step();
    run_load(2'd1, 1'b0, lc, rc, rdy, rs, to);
    total++; if ({to, rdy} !== 2'b01 || lc !== 7) begin bad++; $display("FAIL inv_reload to=%0b rdy=%0b lc=%0d exp=0/1/7", to, rdy, lc); end
    total++; if (bus.grid_mux_sel !== GRID1B) begin bad++; $display("FAIL inv_grid got=%h exp=%h", bus.grid_mux_sel, GRID1B); end
  endtask

  task automatic test_reset_mid_load();
    int lc, rc; bit rdy, to; logic [1:0] rs;
    bus.req_valid = 1'b1; bus.req_rca = 2'd2;
    step();
    bus.req_valid = 1'b0;
    step(); step();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rst_mid_busy got=%b exp=1", bus.busy); end
    bus.io_unit_data_valid_out = 2'b11; bus.io_unit_data_out[0] = 32'h0BADF00D; bus.io_unit_data_out[1] = 32'h0BADF00D;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if ({bus.grid_mux_sel, bus.curr_io_mux_sel, bus.io_unit_output_mode} !== 18'd0) begin
      bad++; $display("FAIL rst_mid_regs got=%h exp=0", {bus.grid_mux_sel, bus.curr_io_mux_sel, bus.io_unit_output_mode});
    end
    total++; if ({bus.io_units_rst, bus.busy, bus.req_ready, bus.rs_data_valid, bus.result_valid, bus.io_fifo_pop} !== 8'd0
                 || bus.result_data !== 32'd0) begin
      bad++; $display("FAIL rst_mid_ctrl got=%b data=%h exp=0", {bus.io_units_rst, bus.busy, bus.req_ready, bus.rs_data_valid, bus.result_valid, bus.io_fifo_pop}, bus.result_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.io_unit_data_valid_out = 2'b00;
    step();
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_idle got=%b exp=0", bus.busy); end
    step();
    run_load(2'd2, 1'b0, lc, rc, rdy, rs, to);
    total++; if ({to, rdy} !== 2'b01 || lc !== 7 || rc !== 1) begin
      bad++; $display("FAIL rst_reload to=%0b rdy=%0b lc=%0d rc=%0d exp=0/1/7/1", to, rdy, lc, rc);
    end
    total++; if (bus.grid_mux_sel !== GRID2 || bus.curr_io_mux_sel !== IOS2 || bus.io_unit_output_mode !== 2'b01) begin
      bad++; $display("FAIL rst_reload_vals got=%h %h %b exp=%h %h 01", bus.grid_mux_sel, bus.curr_io_mux_sel, bus.io_unit_output_mode, GRID2, IOS2);
    end
  endtask

  initial begin
    bus.cfg_wr_en = 1'b0; bus.cfg_wr_rca = 2'd0; bus.cfg_wr_idx = 3'd0; bus.cfg_wr_data = 8'h00;
    bus.req_valid = 1'b0; bus.req_rca = 2'd0; bus.result_ready = 1'b0;
    bus.io_unit_data_out = '0; bus.io_unit_data_valid_out = 2'b00;
    test_reset();
    test_load();
    test_issue_limit();
    test_retire();
    test_drain_switch();
    test_cfg_invalidate();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rca_grid_sched.md
Name: rca_grid_sched

Overview:
- Sequencing controller for the reconfigurable-accelerator PR grid.
- Holds a per-RCA configuration store and loads the selected RCA's mux selects and IO-unit modes into the grid, one entry per cycle, then pulses the IO-unit FIFO reset.
- Gates operand issue into the grid and retires results from the selected output row's IO FIFO.
- Drains in-flight work before switching to a different RCA.

Parameters:
- NUM_RCAS, 4, number of configurable accelerators held in the store.
- GRID_NUM_ROWS, 2, grid rows; also the number of IO units.
- GRID_NUM_COLS, 2, grid columns.
- NUM_GRID_MUXES, GRID_NUM_ROWS*GRID_NUM_COLS, number of PR-slot input muxes.
- GRID_SEL_W, 3, width of a grid mux select.
- IO_SEL_W, 2, width of an IO mux select.
- CFG_DATA_W, 8, width of a config-store entry.
- MAX_OUTSTANDING, 4, maximum number of issued but unretired operations.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- cfg_wr_en  in  1  write one config-store entry.
- cfg_wr_rca  in  clog2(NUM_RCAS)  RCA being written.
- cfg_wr_idx  in  clog2(NUM_GRID_MUXES+GRID_NUM_ROWS+1)  entry index.
- cfg_wr_data  in  CFG_DATA_W  entry value.
- req_valid  in  1  issue request.
- req_rca  in  clog2(NUM_RCAS)  RCA targeted by the request.
- req_ready  out  1  request accepted this cycle.
- rs_data_valid  out  GRID_NUM_ROWS  per-row operand valid into the grid.
- io_unit_data_out  in  XLEN x GRID_NUM_ROWS  IO-unit FIFO heads.
- io_unit_data_valid_out  in  GRID_NUM_ROWS  IO-unit FIFO non-empty.
- io_fifo_pop  out  GRID_NUM_ROWS  per-row FIFO pop.
- result_valid  out  1  result available.
- result_data  out  XLEN  result value.
- result_ready  in  1  writeback accepts the result.
- grid_mux_sel  out  GRID_SEL_W x NUM_GRID_MUXES  grid mux selects (registered).
- curr_io_mux_sel  out  IO_SEL_W x GRID_NUM_ROWS  IO mux selects (registered).
- io_unit_output_mode  out  GRID_NUM_ROWS  IO-unit output mode (registered).
- io_units_rst  out  1  IO FIFO reset pulse.
- busy  out  1  controller is not in IDLE or READY.

Behaviour:
- Config entry layout:
  - idx < NUM_GRID_MUXES: grid mux select, data[GRID_SEL_W-1:0].
  - Next GRID_NUM_ROWS indices: IO unit r; data[IO_SEL_W-1:0] = select, data[7] = output mode.
  - Last index is the meta entry: data[GRID_NUM_ROWS-1:0] = in_row_mask; data[GRID_NUM_ROWS+:clog2(ROWS)] = out_row.
- Config store writes take effect the following cycle. An out-of-range idx is ignored.
- Reset (rst low, asynchronous): state = IDLE; all select and mode registers = 0; loaded_valid = 0; outstanding = 0; dirty = 0; all outputs = 0. The config store is not reset.
- States and transitions:
  - IDLE: req_valid → LOAD; latch target = req_rca; clear dirty.
  - LOAD: counter runs 0..NUM_GRID_MUXES+GRID_NUM_ROWS. Each cycle copies store[target][cnt] into the matching output register (meta goes to internal regs), so LOAD lasts NUM_GRID_MUXES+GRID_NUM_ROWS+1 cycles, then → IO_RST.
  - IO_RST: io_units_rst = 1 for exactly 1 cycle; loaded_rca = target; loaded_valid = !dirty; → READY.
  - READY, request hits (req_valid, req_rca == loaded_rca, loaded_valid): stay in READY.
  - READY, request misses: → LOAD if outstanding == 0, else → DRAIN.
  - DRAIN: → LOAD (target = req_rca) once outstanding == 0 at the start of a cycle.
- A cfg write to loaded_rca clears loaded_valid. A cfg write to target during LOAD or IO_RST sets dirty. Either way the next request reloads.
- req_ready = (state == READY) & loaded_valid & (req_rca == loaded_rca) & (outstanding < MAX_OUTSTANDING). The requester holds req_valid and req_rca until accepted.
- On fire (req_valid & req_ready): rs_data_valid = in_row_mask, combinationally in the same cycle; otherwise 0.
- result_valid = io_unit_data_valid_out[out_row] & (outstanding != 0) & state in {READY, DRAIN}. result_data = io_unit_data_out[out_row].
- io_fifo_pop[out_row] = result_valid & result_ready; all other bits of io_fifo_pop are 0.
- outstanding +1 on fire, -1 on pop, unchanged on both in the same cycle. It never exceeds MAX_OUTSTANDING and never underflows.
- io_units_rst never asserts while outstanding != 0.

Decomposition:
- rca_config package: cfg entry index constants (IO_BASE = NUM_GRID_MUXES, META_IDX), meta field offsets, and the sched_state_t enum {IDLE, LOAD, IO_RST, READY, DRAIN}.
- One sub-module, rca_cfg_store: NUM_RCAS x entries register array with one write port and one combinational read port (rca, idx).

Test Plan:
- Reset, write RCA1 (grid sels 1,2,3,4; IO sels 1,2; mode bits 0,1; meta mask=01, out_row=1), request RCA1 → LOAD for 7 cycles, then grid_mux_sel={1,2,3,4}, curr_io_mux_sel={1,2}, io_unit_output_mode=10, io_units_rst high exactly 1 cycle, req_ready high on the following cycle.
- In READY on RCA1, hold req_valid for 6 cycles with result_ready=0 → exactly 4 fires, rs_data_valid=01 on each, req_ready low thereafter.
- Raise io_unit_data_valid_out[1] with data 0xDEADBEEF and result_ready=1 → result_valid=1, io_fifo_pop=10, outstanding decrements; a fire in the same cycle leaves outstanding unchanged.
- With outstanding=2, request RCA2 → DRAIN, no io_units_rst; after 2 pops → LOAD of RCA2, then io_units_rst.
- Write RCA1 entry 0 while RCA1 is loaded → req_ready drops; the next RCA1 request reloads with the new value visible on grid_mux_sel[0].
- Assert rst mid-LOAD → all outputs 0 immediately and state IDLE; config store contents retained, so the next request loads the same values.
